dispatch_hazard_table: RTL and testbench

- Parametrised in-flight register table for the dispatch stage.
- Each entry holds {rs1, rs2, rW} plus a valid bit, one entry per pipeline slot.
- Adds per-entry valid tracking, a correct delete path, a flush, an occupancy count with full/empty, a sticky protocol-error flag, and combinational RAW hazard detection of two query source registers against in-flight destinations.
- Sits between decode and issue; its stall output gates dispatch.

---
 rtl/dispatch_hazard_table.sv | 154 +++++++++++++++
 tb/tb_dispatch_hazard_table.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_hazard_table.sv
// In-flight register table for the dispatch stage.
// One entry per pipeline slot holds {rs1, rs2, rW} plus a valid bit. The table
// tracks occupancy, flags protocol misuse stickily, and compares two query
// source registers against every in-flight destination to produce a RAW stall.
module dispatch_hazard_table #(
  parameter int CORE          = 0,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STAGES        = 4,
  parameter int INDEX_WIDTH   = 2,
  parameter int COUNT_WIDTH   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       reg_insert,
  input  logic [ADDRESS_WIDTH-1:0]   reg_rs1,
  input  logic [ADDRESS_WIDTH-1:0]   reg_rs2,
  input  logic [ADDRESS_WIDTH-1:0]   reg_rW,
  input  logic [INDEX_WIDTH-1:0]     reg_indexIns,
  input  logic                       reg_delete,
  input  logic [INDEX_WIDTH-1:0]     reg_indexDel,
  input  logic                       reg_flush,
  input  logic [INDEX_WIDTH-1:0]     reg_indexRead,
  output logic [3*ADDRESS_WIDTH-1:0] reg_outRead,
  output logic                       reg_outValid,
  input  logic [ADDRESS_WIDTH-1:0]   chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0]   chk_rs2,
  output logic [STAGES-1:0]          chk_hit1,
  output logic [STAGES-1:0]          chk_hit2,
  output logic                       chk_stall,
  output logic [COUNT_WIDTH-1:0]     reg_count,
  output logic                       reg_full,
  output logic                       reg_empty,
  output logic                       reg_error
);

  localparam int DW = 3 * ADDRESS_WIDTH;

  // The core identifier is informational only.
  logic unused_core;
  assign unused_core = ^CORE;

  logic [DW-1:0]          entry_data [STAGES];
  logic [STAGES-1:0]      valid_reg;
  logic [STAGES-1:0]      ins_sel;
  logic [STAGES-1:0]      del_sel;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   error_reg;
  logic                   error_next;

  // An index is usable only if it names an existing slot; the extra top bit
  // keeps the comparison meaningful when 2^INDEX_WIDTH == STAGES.
  logic ins_in_range;
  logic del_in_range;
  logic ins_ok;
  logic del_ok;
  logic ins_on_valid;
  logic del_on_valid;
  logic same_index;

  assign ins_in_range = ({1'b0, reg_indexIns} < (INDEX_WIDTH+1)'(STAGES));
  assign del_in_range = ({1'b0, reg_indexDel} < (INDEX_WIDTH+1)'(STAGES));
  assign ins_ok       = reg_insert && ins_in_range;
  assign del_ok       = reg_delete && del_in_range;
  assign ins_on_valid = |(ins_sel & valid_reg);
  assign del_on_valid = |(del_sel & valid_reg);
  assign same_index   = ins_ok && del_ok && (reg_indexIns == reg_indexDel);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_entry
      logic [DW-1:0] data_reg;
      logic          valid_bit_reg;

      assign ins_sel[gi]    = ins_ok && (reg_indexIns == INDEX_WIDTH'(gi));
      assign del_sel[gi]    = del_ok && (reg_indexDel == INDEX_WIDTH'(gi));
      assign entry_data[gi] = data_reg;
      assign valid_reg[gi]  = valid_bit_reg;

      // Entry update: flush beats insert, insert beats delete on the same slot.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          data_reg      <= '0;
          valid_bit_reg <= 1'b0;
        end else if (reg_flush) begin
          data_reg      <= '0;
          valid_bit_reg <= 1'b0;
        end else if (ins_sel[gi]) begin
          data_reg      <= {reg_rs1, reg_rs2, reg_rW};
          valid_bit_reg <= 1'b1;
        end else if (del_sel[gi]) begin
          data_reg      <= '0;
          valid_bit_reg <= 1'b0;
        end
      end

      // Destination in the low field; register 0 is never a hazard.
      assign chk_hit1[gi] = valid_bit_reg && (chk_rs1 != '0) &&
                            (data_reg[ADDRESS_WIDTH-1:0] == chk_rs1);
      assign chk_hit2[gi] = valid_bit_reg && (chk_rs2 != '0) &&
                            (data_reg[ADDRESS_WIDTH-1:0] == chk_rs2);
    end
  endgenerate

  // Occupancy delta and protocol-error detection for this cycle's operations.
  always_comb begin
    count_next = count_reg;
    error_next = error_reg;
    if (reg_flush) begin
      count_next = '0;
    end else begin
      if (ins_ok && !ins_on_valid) begin
        count_next = count_next + COUNT_WIDTH'(1);
      end
      if (del_ok && del_on_valid && !same_index) begin
        count_next = count_next - COUNT_WIDTH'(1);
      end
      if ((reg_insert && !ins_in_range) || (reg_delete && !del_in_range) ||
          (ins_ok && ins_on_valid) || (del_ok && !del_on_valid)) begin
        error_next = 1'b1;
      end
    end
  end

  // Counter and sticky error advance on the same edge as the valid bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  // Read port: invalid or out-of-range slots read as zero.
  always_comb begin
    reg_outRead  = '0;
    reg_outValid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if ((reg_indexRead == INDEX_WIDTH'(i)) && valid_reg[i]) begin
        reg_outRead  = entry_data[i];
        reg_outValid = 1'b1;
      end
    end
  end

  assign chk_stall = (|chk_hit1) | (|chk_hit2);
  assign reg_count = count_reg;
  assign reg_full  = (count_reg == COUNT_WIDTH'(STAGES));
  assign reg_empty = (count_reg == '0);
  assign reg_error = error_reg;

endmodule

// File: tb/tb_dispatch_hazard_table.sv
// Scoreboard bench for dispatch_hazard_table. A 3-bit index on a 4-slot table
// lets out-of-range indices be exercised.
module tb_dispatch_hazard_table;

  localparam int AW = 5;
  localparam int ST = 4;
  localparam int IW = 3;
  localparam int CW = 3;

  typedef struct packed {
    logic [3*AW-1:0] rd;
    logic            vld;
    logic [ST-1:0]   h1;
    logic [ST-1:0]   h2;
    logic            stall;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            empty;
    logic            err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic reg_insert = 1'b0;
  logic [AW-1:0] reg_rs1 = '0, reg_rs2 = '0, reg_rW = '0;
  logic [IW-1:0] reg_indexIns = '0, reg_indexDel = '0, reg_indexRead = '0;
  logic reg_delete = 1'b0, reg_flush = 1'b0;
  logic [AW-1:0] chk_rs1 = '0, chk_rs2 = '0;
  logic [3*AW-1:0] reg_outRead;
  logic reg_outValid, chk_stall, reg_full, reg_empty, reg_error;
  logic [ST-1:0] chk_hit1, chk_hit2;
  logic [CW-1:0] reg_count;

  dispatch_hazard_table #(
    .CORE(0), .ADDRESS_WIDTH(AW), .STAGES(ST), .INDEX_WIDTH(IW), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .reg_insert(reg_insert), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rW(reg_rW),
    .reg_indexIns(reg_indexIns), .reg_delete(reg_delete), .reg_indexDel(reg_indexDel),
    .reg_flush(reg_flush), .reg_indexRead(reg_indexRead),
    .reg_outRead(reg_outRead), .reg_outValid(reg_outValid),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .chk_stall(chk_stall), .reg_count(reg_count), .reg_full(reg_full),
    .reg_empty(reg_empty), .reg_error(reg_error)
  );

  always #5 clock = ~clock;

  // Reference model: plain per-slot contents, count derived by counting.
  bit            m_valid [ST];
  logic [AW-1:0] m_rs1 [ST], m_rs2 [ST], m_rw [ST];
  bit            m_err;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t actual_now();
    exp_t a;
    a.rd = reg_outRead; a.vld = reg_outValid; a.h1 = chk_hit1; a.h2 = chk_hit2;
    a.stall = chk_stall; a.cnt = reg_count; a.full = reg_full;
    a.empty = reg_empty; a.err = reg_error;
    return a;
  endfunction

  function automatic exp_t model_outputs(int ridx, logic [AW-1:0] c1, logic [AW-1:0] c2);
    exp_t e;
    int n;
    e = '0;
    n = 0;
    if (ridx < ST && m_valid[ridx]) begin
      e.rd  = {m_rs1[ridx], m_rs2[ridx], m_rw[ridx]};
      e.vld = 1'b1;
    end
    for (int i = 0; i < ST; i++) begin
      if (m_valid[i]) n++;
      if (m_valid[i] && c1 != 0 && m_rw[i] == c1) e.h1[i] = 1'b1;
      if (m_valid[i] && c2 != 0 && m_rw[i] == c2) e.h2[i] = 1'b1;
    end
    e.stall = (e.h1 != 0) || (e.h2 != 0);
    e.cnt   = CW'(n);
    e.full  = (n == ST);
    e.empty = (n == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ST; i++) begin
      m_valid[i] = 0; m_rs1[i] = '0; m_rs2[i] = '0; m_rw[i] = '0;
    end
  endtask

  // Effect of one clock edge: delete applied before insert so insert wins a tie.
  task automatic model_apply(bit ins, int ii, logic [AW-1:0] r1, logic [AW-1:0] r2,
                             logic [AW-1:0] rw, bit del, int di, bit fl);
    if (fl) begin
      model_clear();
    end else begin
      if (ins && ii >= ST) m_err = 1;
      if (del && di >= ST) m_err = 1;
      if (ins && ii < ST && m_valid[ii]) m_err = 1;
      if (del && di < ST && !m_valid[di]) m_err = 1;
      if (del && di < ST) begin
        m_valid[di] = 0; m_rs1[di] = '0; m_rs2[di] = '0; m_rw[di] = '0;
      end
      if (ins && ii < ST) begin
        m_valid[ii] = 1; m_rs1[ii] = r1; m_rs2[ii] = r2; m_rw[ii] = rw;
      end
    end
  endtask

  // One transaction: drive after the edge, record what the outputs must show
  // this cycle, then advance the model past the coming edge.
  task automatic step(bit ins, int ii, int r1, int r2, int rw, bit del, int di,
                      bit fl, int ri, int c1, int c2);
    @(posedge clock);
    #1;
    reg_insert = ins; reg_indexIns = IW'(ii);
    reg_rs1 = AW'(r1); reg_rs2 = AW'(r2); reg_rW = AW'(rw);
    reg_delete = del; reg_indexDel = IW'(di);
    reg_flush = fl; reg_indexRead = IW'(ri);
    chk_rs1 = AW'(c1); chk_rs2 = AW'(c2);
    exp_q.push_back(model_outputs(ri, AW'(c1), AW'(c2)));
    model_apply(ins, ii, AW'(r1), AW'(r2), AW'(rw), del, di, fl);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear with no clock edge.
  task automatic async_reset_check();
    exp_t e, a;
    @(posedge clock);
    #1;
    reg_insert = 0; reg_delete = 0; reg_flush = 0;
    reg_indexRead = '0; chk_rs1 = AW'(3); chk_rs2 = AW'(1);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    e = '0;
    e.empty = 1'b1;
    a = actual_now();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL async_reset got=%h required=%h", a, e);
    end else begin
      $display("async_reset outputs cleared ok");
    end
    model_clear();
    m_err = 0;
    #1;
    reset = 1'b1;
  endtask

  function automatic int pick_idx();
    int r;
    r = $urandom_range(0, 15);
    if (r < 14) return r % ST;
    return ST + $urandom_range(0, 3);
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual_now();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d got rd=%h v=%b h1=%b h2=%b st=%b cnt=%0d f=%b e=%b err=%b required rd=%h v=%b h1=%b h2=%b st=%b cnt=%0d f=%b e=%b err=%b",
                   vectors, a.rd, a.vld, a.h1, a.h2, a.stall, a.cnt, a.full, a.empty, a.err,
                   e.rd, e.vld, e.h1, e.h2, e.stall, e.cnt, e.full, e.empty, e.err);
        end else begin
          $display("vec%0d rd=%h v=%b hits=%b/%b cnt=%0d err=%b", vectors, a.rd, a.vld,
                   a.h1, a.h2, a.cnt, a.err);
        end
      end
    end
  end

  initial begin
    int t;
    model_clear();
    m_err = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Idle, then fill all four slots.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < ST; i++) step(1, i, 5, 6, i + 1, 0, 0, 0, 2, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0);   // full, read {5,6,3}, hit1=0100
    step(0, 0, 0, 0, 0, 0, 0, 0, 2, 9, 0);   // no stall
    // Same-slot insert+delete on valid slot: insert wins, error set.
    step(1, 1, 5, 6, 7, 1, 1, 0, 1, 7, 0);
    step(1, 0, 1, 2, 8, 1, 3, 0, 1, 7, 4);   // different slots
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 8, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 2);

    // Delete of an invalid slot.
    async_reset_check();
    step(1, 0, 1, 1, 2, 0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);

    // Out-of-range insert is ignored but flagged.
    async_reset_check();
    step(1, 5, 3, 3, 3, 0, 0, 0, 5, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3);

    // Flush beats a concurrent insert on a full table.
    async_reset_check();
    for (int i = 0; i < ST; i++) step(1, i, 5, 6, i + 1, 0, 0, 0, 0, 1, 2);
    step(1, 0, 9, 9, 9, 1, 2, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);

    // Randomised traffic with small register numbers so hazards are common.
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) async_reset_check();
      step($urandom_range(0, 1), pick_idx(), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), ($urandom_range(0, 2) == 0), pick_idx(),
           ($urandom_range(0, 19) == 0), pick_idx(), $urandom_range(0, 7),
           $urandom_range(0, 7));
    end

    t = 0;
    while (exp_q.size() > 0 && t < 10) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
